// File: rtl/pwm_seq_ctrl.sv
// PWM reference sequencer: precharge, run and fault sequencing with a
// carrier-synchronous shadow buffer for the three phase references.
module pwm_seq_ctrl #(
   parameter int unsigned PRECHG_CYC = 1000,
   parameter logic [22:0] MAG_MAX    = 23'h22BF10,
   parameter int unsigned WDOG_SYNCS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        stop,
   input  logic        fault_in,
   input  logic        fault_clr,
   input  logic        carrier_sync,
   input  logic        ref_valid,
   output logic        ref_ready,
   input  logic [23:0] ua_in,
   input  logic [23:0] ub_in,
   input  logic [23:0] uc_in,
   output logic [23:0] ua_out,
   output logic [23:0] ub_out,
   output logic [23:0] uc_out,
   output logic        gate_en,
   output logic        low_side_on,
   output logic [1:0]  state,
   output logic        fault_latched,
   output logic [7:0]  stale_cnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PRECHG = 2'd1,
      RUN    = 2'd2,
      FAULT  = 2'd3
   } state_t;

   localparam int CW = $clog2(PRECHG_CYC + 1);
   localparam int SW = $clog2(WDOG_SYNCS + 1);
   localparam logic [CW-1:0] PRE_LOAD = CW'(PRECHG_CYC - 1);
   localparam logic [SW-1:0] WDOG_LIM = SW'(WDOG_SYNCS);

   state_t        stateQ, stateD;
   logic [CW-1:0] preCntQ, preCntD;
   logic [SW-1:0] consQ, consD, consInc;
   logic          pendQ, pendD;
   logic [23:0]   shUaQ, shUbQ, shUcQ;
   logic [23:0]   shUaD, shUbD, shUcD;
   logic [23:0]   uaD, ubD, ucD;
   logic [7:0]    staleD;
   logic          gateD, lowD, fltD;
   logic          accept, loadOut;

   function automatic logic [23:0] clampRef(input logic [23:0] v);
      return (v[22:0] > MAG_MAX) ? {v[23], MAG_MAX} : v;
   endfunction

   assign ref_ready = ~pendQ & ((stateQ == PRECHG) | (stateQ == RUN));
   assign accept    = ref_valid & ref_ready;
   assign consInc   = consQ + SW'(1);
   assign state     = stateQ;

   always_comb begin
      stateD  = stateQ;
      preCntD = preCntQ;
      consD   = consQ;
      pendD   = pendQ;
      shUaD   = shUaQ;
      shUbD   = shUbQ;
      shUcD   = shUcQ;
      uaD     = ua_out;
      ubD     = ub_out;
      ucD     = uc_out;
      staleD  = stale_cnt;
      loadOut = 1'b0;
      unique case (stateQ)
         IDLE: begin
            if (fault_in) begin
               stateD = FAULT;
            end else if (!stop && start) begin
               stateD  = PRECHG;
               preCntD = PRE_LOAD;
            end
         end
         PRECHG: begin
            if (fault_in) begin
               stateD = FAULT;
            end else if (stop) begin
               stateD = IDLE;
            end else if (carrier_sync && preCntQ == '0) begin
               stateD  = RUN;
               loadOut = pendQ;
            end else if (preCntQ != '0) begin
               preCntD = preCntQ - CW'(1);
            end
         end
         RUN: begin
            if (fault_in) begin
               stateD = FAULT;
            end else if (stop) begin
               stateD = IDLE;
            end else if (carrier_sync) begin
               if (pendQ) begin
                  loadOut = 1'b1;
               end else begin
                  if (stale_cnt != 8'hFF) staleD = stale_cnt + 8'd1;
                  consD = consInc;
                  if (consInc == WDOG_LIM) stateD = FAULT;
               end
            end
         end
         FAULT: begin
            if (fault_clr && !fault_in) stateD = IDLE;
         end
      endcase
      // accept can only coincide with a stale sync, never with a load
      if (accept) begin
         shUaD = clampRef(ua_in);
         shUbD = clampRef(ub_in);
         shUcD = clampRef(uc_in);
         pendD = 1'b1;
      end
      if (loadOut) begin
         uaD   = shUaQ;
         ubD   = shUbQ;
         ucD   = shUcQ;
         pendD = 1'b0;
         consD = '0;
      end
      if (stateD == IDLE || stateD == FAULT) begin
         uaD     = '0;
         ubD     = '0;
         ucD     = '0;
         pendD   = 1'b0;
         consD   = '0;
         preCntD = '0;
      end
      gateD = (stateD == RUN);
      lowD  = (stateD == PRECHG);
      fltD  = (stateD == FAULT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stateQ        <= IDLE;
         preCntQ       <= '0;
         consQ         <= '0;
         pendQ         <= 1'b0;
         shUaQ         <= '0;
         shUbQ         <= '0;
         shUcQ         <= '0;
         ua_out        <= '0;
         ub_out        <= '0;
         uc_out        <= '0;
         stale_cnt     <= '0;
         gate_en       <= 1'b0;
         low_side_on   <= 1'b0;
         fault_latched <= 1'b0;
      end else begin
         stateQ        <= stateD;
         preCntQ       <= preCntD;
         consQ         <= consD;
         pendQ         <= pendD;
         shUaQ         <= shUaD;
         shUbQ         <= shUbD;
         shUcQ         <= shUcD;
         ua_out        <= uaD;
         ub_out        <= ubD;
         uc_out        <= ucD;
         stale_cnt     <= staleD;
         gate_en       <= gateD;
         low_side_on   <= lowD;
         fault_latched <= fltD;
      end
   end

endmodule

// File: doc/pwm_seq_ctrl.md
PWM_SEQ_CTRL -- requirements
Module: pwm_seq_ctrl

Interface
REQ-001 SHALL have parameter PRECHG_CYC, default 1000, meaning the number of clk cycles the low side is forced on before RUN.
REQ-002 SHALL have parameter MAG_MAX, default 23'h22BF10, meaning the clamp limit for the reference magnitude (bits [22:0]).
REQ-003 SHALL have parameter WDOG_SYNCS, default 4, meaning consecutive carrier syncs in RUN without a new reference before a stale fault.
REQ-004 SHALL have ports, in order:
  clk  in  1  single clock; all logic on posedge
  reset  in  1  synchronous, active-high
  start  in  1  level; request start from IDLE
  stop  in  1  level; request return to IDLE
  fault_in  in  1  level; external hardware trip
  fault_clr  in  1  level; acknowledge fault
  carrier_sync  in  1  one-clk pulse at carrier extreme
  ref_valid  in  1  new Ua/Ub/Uc triple offered
  ref_ready  out  1  triple accepted this cycle when ref_valid=1
  ua_in, ub_in, uc_in  in  24 each  bit23 sign, [22:0] magnitude
  ua_out, ub_out, uc_out  out  24 each  references to modulator
  gate_en  out  1  enable for gate drivers
  low_side_on  out  1  force all low-side switches on
  state  out  2  IDLE=0, PRECHG=1, RUN=2, FAULT=3
  fault_latched  out  1  1 while in FAULT
  stale_cnt  out  8  saturating count of RUN syncs without new ref

Function
REQ-005 SHALL use a one-entry shadow buffer with a pending flag, and ref_ready = ~pending while state is PRECHG or RUN, else 0.
REQ-006 SHALL accept on ref_valid & ref_ready: store each input with magnitude clamped to MAG_MAX (sign kept), and set pending.
REQ-007 SHALL hold ua_out/ub_out/uc_out constant except on carrier_sync in RUN; no mid-carrier update.
REQ-008 SHALL, on carrier_sync in RUN with pending=1, load the shadow into the outputs (visible the next cycle), clear pending and reset the consecutive-stale counter.
REQ-009 SHALL, on carrier_sync in RUN with pending=0, hold the outputs, increment stale_cnt (saturating at 255) and increment the consecutive-stale counter.
REQ-010 SHALL, when accept and carrier_sync coincide with pending=0, store the new triple as pending and treat that sync as stale; the triple applies at the next sync.
REQ-011 SHALL enter FAULT when the consecutive-stale counter reaches WDOG_SYNCS.
REQ-012 SHALL take IDLE -> PRECHG on start=1, loading the precharge counter with PRECHG_CYC-1.
REQ-013 SHALL, in PRECHG, assert low_side_on=1 and gate_en=0 and decrement the counter to 0, holding at 0.
REQ-014 SHALL take PRECHG -> RUN on the first carrier_sync with counter=0, loading a pending triple on that same sync if present.
REQ-015 SHALL, in RUN, assert gate_en=1 and low_side_on=0.
REQ-016 SHALL take PRECHG or RUN -> IDLE on stop=1.
REQ-017 SHALL take FAULT -> IDLE only when fault_clr=1 and fault_in=0.
REQ-018 SHALL take any non-FAULT state -> FAULT on fault_in=1.
REQ-019 SHALL apply transition priority fault_in > stop > start/sync/stale.
REQ-020 SHALL, on entry to IDLE or FAULT, zero ua_out/ub_out/uc_out, deassert gate_en and low_side_on, clear pending and the consecutive-stale counter, and preserve stale_cnt.
REQ-021 SHALL register all outputs except ref_ready; state changes are visible one clk after the causing input.

Reset
REQ-022 SHALL, while reset=1 at posedge clk, force state=IDLE, all *_out=24'h0, gate_en=0, low_side_on=0, fault_latched=0, stale_cnt=0, pending=0 and the precharge counter=0, overriding all other inputs.
REQ-023 SHALL, on reset mid-RUN, deassert gate_en on the next clk edge with no drain of the pending triple.

Verification
REQ-024 SHALL cover startup with PRECHG_CYC=8: reset, then start pulse -> state=1 and low_side_on=1 for 8 cycles, then RUN on the next carrier_sync with gate_en=1.
REQ-025 SHALL cover update timing: in RUN, offer ua_in=24'h000100 mid-carrier -> ua_out unchanged until the sync, then equals 24'h000100 one clk after the sync.
REQ-026 SHALL cover clamp and backpressure: offer ua_in=24'h7FFFFF -> ua_out=24'h22BF10; a second ref_valid before the sync -> ref_ready=0, and the first triple is kept.
REQ-027 SHALL cover the stale watchdog with WDOG_SYNCS=4: 4 syncs with no refs -> stale_cnt=4, state=3, gate_en=0, outputs zero; fault_clr with fault_in=1 -> stays in FAULT; fault_in=0 -> IDLE.
REQ-028 SHALL cover priority: fault_in, stop and carrier_sync asserted in the same cycle in RUN -> state=3 and the pending triple is discarded.
REQ-029 SHALL cover synchronous reset mid-RUN: reset high for 1 clk -> all outputs at reset values at the following edge, and stale_cnt=0.
